// File: rtl/ones_frame_accum_if.sv
// ones_frame_accum_if
// Groups the word-in / frame-total-out handshake of ones_frame_accum.
//
// Handshake rules, both ports:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The sender holds its data stable while valid=1 and ready=0.
//   Input port : cnt_in/in_valid from the counter stage, in_ready back to it.
//   Output port: sum_out/ovf/out_valid to downstream, out_ready from it.
//
// Modports:
//   slave  - the accumulator (consumes words, produces totals)
//   master - the environment (produces words, consumes totals)
//
// Parameter SUM_W must match the SUM_W of the attached accumulator.
interface ones_frame_accum_if #(
  parameter int SUM_W = 8
) ();

  logic [3:0]       cnt_in;
  logic             in_valid;
  logic             in_ready;
  logic [SUM_W-1:0] sum_out;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  cnt_in,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output sum_out,
    output ovf,
    output out_valid
  );

  modport master (
    output cnt_in,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  sum_out,
    input  ovf,
    input  out_valid
  );

endinterface

// File: rtl/ones_frame_accum.sv
// ones_frame_accum
// Sums the 4-bit ones counts of FRAME_LEN accepted words and presents each
// frame total on a valid/ready output with full backpressure upstream.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   clr        synchronous clear of the partial frame and the output register;
//              beats both the input word and the output handshake
//   bus        ones_frame_accum_if.slave
//                cnt_in/in_valid/in_ready  : word input (0..15 per word)
//                sum_out/ovf/out_valid/out_ready : frame total output
//   dbg_state  current FSM state (0 = ACCUM, 1 = FULL), for observation only
//
// Parameters:
//   FRAME_LEN  words per frame, 1..255
//   SUM_W      accumulator / sum_out width, 4..16
//
// Build option:
//   ONES_ACC_SAT_EN  defined   : the total saturates at 2^SUM_W-1 once any
//                                addition in the frame carries out
//                    undefined : the total wraps modulo 2^SUM_W
//   ovf reports a carry-out anywhere in the frame in both builds, and the
//   handshake timing is identical.
module ones_frame_accum #(
  parameter int FRAME_LEN = 8,
  parameter int SUM_W     = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  ones_frame_accum_if.slave   bus,
  output logic                dbg_state
);

  // idx needs at least one bit even when every word is its own frame.
  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

`ifdef ONES_ACC_SAT_EN
  localparam logic [SUM_W-1:0] SUM_MAX = '1;
`endif

  // ACCUM: no result pending. FULL: sum_out/ovf hold a completed frame.
  typedef enum logic {
    ACCUM = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_q,   state_d;
  logic [SUM_W-1:0] acc_q,     acc_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [SUM_W-1:0] sum_q,     sum_d;
  logic             ovf_q,     ovf_d;

  logic             accept;
  logic             last;
  logic [SUM_W:0]   sum_wide;
  logic             carry;
  logic             ovf_step;
  logic [SUM_W-1:0] acc_step;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  // A word can be taken whenever the output slot is empty or is being drained
  // in the same cycle, which lets completed frames stream with no bubble.
  assign bus.in_ready  = (state_q == ACCUM) || bus.out_ready;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = (idx_q == IDX_LAST);

  assign bus.sum_out   = sum_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = (state_q == FULL);
  assign dbg_state     = state_q;

  // ---------------------------------------------------------------------------
  // Datapath: one extra bit captures the carry-out of each addition.
  // ---------------------------------------------------------------------------
  assign sum_wide = {1'b0, acc_q} + {{(SUM_W - 3){1'b0}}, bus.cnt_in};
  assign carry    = sum_wide[SUM_W];
  assign ovf_step = acc_ovf_q | carry;

`ifdef ONES_ACC_SAT_EN
  // Once overflowed, the accumulator is pinned at the maximum; later words
  // may not carry again, so the sticky flag keeps it clamped.
  assign acc_step = ovf_step ? SUM_MAX : sum_wide[SUM_W-1:0];
`else
  assign acc_step = sum_wide[SUM_W-1:0];
`endif

  // ---------------------------------------------------------------------------
  // Next-state / next-datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_ovf_d = acc_ovf_q;
    idx_d     = idx_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;

    if (clr) begin
      // The word presented with clr is dropped and any pending result lost.
      state_d   = ACCUM;
      acc_d     = '0;
      acc_ovf_d = 1'b0;
      idx_d     = '0;
      sum_d     = '0;
      ovf_d     = 1'b0;
    end else begin
      // Drain first; a completing word below overrides this back to FULL.
      if ((state_q == FULL) && bus.out_ready) begin
        state_d = ACCUM;
      end

      if (accept) begin
        if (last) begin
          sum_d     = acc_step;
          ovf_d     = ovf_step;
          state_d   = FULL;
          acc_d     = '0;
          acc_ovf_d = 1'b0;
          idx_d     = '0;
        end else begin
          acc_d     = acc_step;
          acc_ovf_d = ovf_step;
          idx_d     = idx_q + 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      acc_q     <= '0;
      acc_ovf_q <= 1'b0;
      idx_q     <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_ovf_q <= acc_ovf_d;
      idx_q     <= idx_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule

// File: tb/tb_ones_frame_accum.sv
// tb_ones_frame_accum
// Three accumulators: A (FRAME_LEN=4, SUM_W=8), B (FRAME_LEN=3, SUM_W=5),
// C (FRAME_LEN=1, SUM_W=8). Only one is exercised at a time. Each cycle's
// inputs and hand-derived in_ready/out_valid/sum_out come from a vector
// table; frame totals are predicted from the true running sum and queued,
// then popped when the DUT's output handshake completes.
module tb_ones_frame_accum;

  logic clk = 1'b0;
  logic rst_n;
  logic clr_a, clr_b, clr_c;
  logic dbg_a, dbg_b, dbg_c;

  always #5 clk = ~clk;

  ones_frame_accum_if #(.SUM_W(8)) ifa ();
  ones_frame_accum_if #(.SUM_W(5)) ifb ();
  ones_frame_accum_if #(.SUM_W(8)) ifc ();

  ones_frame_accum #(.FRAME_LEN(4), .SUM_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr_a), .bus(ifa), .dbg_state(dbg_a));
  ones_frame_accum #(.FRAME_LEN(3), .SUM_W(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr_b), .bus(ifb), .dbg_state(dbg_b));
  ones_frame_accum #(.FRAME_LEN(1), .SUM_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr_c), .bus(ifc), .dbg_state(dbg_c));

`ifdef ONES_ACC_SAT_EN
  localparam int B_OVF_SUM = 31;
`else
  localparam int B_OVF_SUM = 13;
`endif

  typedef struct {
    int id;
    bit c;
    bit v;
    int cnt;
    bit ordy;
    bit ir;
    bit ov;
    int sum;   // -1: sum_out not checked this cycle
  } vec_t;

  vec_t        vecs[$];
  logic [16:0] exp_q[$];   // {ovf, sum_out zero-extended}
  int          total = 0;
  int          bad   = 0;
  int          tot_m = 0;
  int          nw_m  = 0;
  int          cur   = 0;

  function automatic int flen(input int id);
    return (id == 0) ? 4 : (id == 1) ? 3 : 1;
  endfunction

  function automatic int swid(input int id);
    return (id == 1) ? 5 : 8;
  endfunction

  function automatic void add_vec(input int id, input bit c, input bit v,
                                  input int cnt, input bit ordy, input bit ir,
                                  input bit ov, input int sum);
    vec_t t;
    t.id = id; t.c = c; t.v = v; t.cnt = cnt; t.ordy = ordy;
    t.ir = ir; t.ov = ov; t.sum = sum;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s (step %0d): got %0d expected %0d", name, cur, act, exp);
    end
  endtask

  task automatic model_reset();
    tot_m = 0;
    nw_m  = 0;
    exp_q.delete();
  endtask

  // One clock cycle: drive at the falling edge, sample 1ns later, and update
  // the scoreboard with what the coming rising edge will do.
  task automatic step(input int id, input bit c, input bit v, input int cnt,
                      input bit ordy, input bit ir_e, input bit ov_e,
                      input int sum_e);
    bit ir, ov, of;
    int so, st, mx, s;
    bit of_e;
    logic [16:0] want, got;
    ir = 0; ov = 0; of = 0; so = 0; st = 0;
    @(negedge clk);
    case (id)
      0: begin clr_a = c; ifa.in_valid = v; ifa.cnt_in = 4'(cnt); ifa.out_ready = ordy; end
      1: begin clr_b = c; ifb.in_valid = v; ifb.cnt_in = 4'(cnt); ifb.out_ready = ordy; end
      default: begin clr_c = c; ifc.in_valid = v; ifc.cnt_in = 4'(cnt); ifc.out_ready = ordy; end
    endcase
    #1;
    case (id)
      0: begin ir = ifa.in_ready; ov = ifa.out_valid; of = ifa.ovf; so = int'(ifa.sum_out); st = int'(dbg_a); end
      1: begin ir = ifb.in_ready; ov = ifb.out_valid; of = ifb.ovf; so = int'(ifb.sum_out); st = int'(dbg_b); end
      default: begin ir = ifc.in_ready; ov = ifc.out_valid; of = ifc.ovf; so = int'(ifc.sum_out); st = int'(dbg_c); end
    endcase
    chk($sformatf("dut%0d in_ready", id), int'(ir), int'(ir_e));
    chk($sformatf("dut%0d out_valid", id), int'(ov), int'(ov_e));
    chk($sformatf("dut%0d dbg_state", id), st, int'(ov_e));
    if (sum_e >= 0) chk($sformatf("dut%0d sum_out", id), so, sum_e);

    if (c) begin
      model_reset();
    end else begin
      if (ov && ordy) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL dut%0d result (step %0d): got sum=%0d ovf=%0d expected none", id, cur, so, of);
        end else begin
          want = exp_q.pop_front();
          got  = {of, 16'(so)};
          chk($sformatf("dut%0d frame result {ovf,sum}", id), int'(got), int'(want));
        end
      end
      if (v && ir) begin
        tot_m += cnt;
        nw_m++;
        if (nw_m == flen(id)) begin
          mx   = (1 << swid(id)) - 1;
          of_e = (tot_m > mx);
`ifdef ONES_ACC_SAT_EN
          s = of_e ? mx : tot_m;
`else
          s = tot_m % (mx + 1);
`endif
          exp_q.push_back({of_e, 16'(s)});
          tot_m = 0;
          nw_m  = 0;
        end
      end
    end
    cur++;
  endtask

  initial begin
    // ---- vector table ------------------------------------------------------
    // A: 15,15,15,15 with out_ready=1 -> 60, drops next cycle
    for (int i = 0; i < 4; i++) add_vec(0, 0, 1, 15, 1, 1, 0, -1);
    add_vec(0, 0, 0, 0, 1, 1, 1, 60);
    add_vec(0, 0, 0, 0, 1, 1, 0, 60);
    // A: 3,0,7,5 held, next frame blocked until out_ready, then 1,1,1,1 -> 4
    add_vec(0, 0, 1, 3, 0, 1, 0, -1);
    add_vec(0, 0, 1, 0, 0, 1, 0, -1);
    add_vec(0, 0, 1, 7, 0, 1, 0, -1);
    add_vec(0, 0, 1, 5, 0, 1, 0, -1);
    add_vec(0, 0, 1, 1, 0, 0, 1, 15);
    add_vec(0, 0, 1, 1, 0, 0, 1, 15);
    add_vec(0, 0, 1, 1, 1, 1, 1, 15);
    for (int i = 0; i < 3; i++) add_vec(0, 0, 1, 1, 1, 1, 0, 15);
    add_vec(0, 0, 0, 0, 1, 1, 1, 4);
    add_vec(0, 0, 0, 0, 1, 1, 0, 4);
    // A: 9,9, clr (word dropped), 2,2,2,2 -> only 8
    add_vec(0, 0, 1, 9, 1, 1, 0, -1);
    add_vec(0, 0, 1, 9, 1, 1, 0, -1);
    add_vec(0, 1, 1, 9, 1, 1, 0, -1);
    for (int i = 0; i < 4; i++) add_vec(0, 0, 1, 2, 1, 1, 0, 0);
    add_vec(0, 0, 0, 0, 1, 1, 1, 8);
    add_vec(0, 0, 0, 0, 1, 1, 0, 8);
    // A: clr while a result is held discards it
    for (int i = 0; i < 4; i++) add_vec(0, 0, 1, 1, 0, 1, 0, 8);
    add_vec(0, 0, 0, 0, 0, 0, 1, 4);
    add_vec(0, 1, 0, 0, 0, 0, 1, 4);
    add_vec(0, 0, 0, 0, 1, 1, 0, 0);
    // B: 15,15,15 overflows; 3,4,5 -> 12; 15,15,0 -> 30 without overflow
    for (int i = 0; i < 3; i++) add_vec(1, 0, 1, 15, 1, 1, 0, -1);
    add_vec(1, 0, 1, 3, 1, 1, 1, B_OVF_SUM);
    add_vec(1, 0, 1, 4, 1, 1, 0, -1);
    add_vec(1, 0, 1, 5, 1, 1, 0, -1);
    add_vec(1, 0, 1, 15, 1, 1, 1, 12);
    add_vec(1, 0, 1, 15, 1, 1, 0, 12);
    add_vec(1, 0, 1, 0, 1, 1, 0, 12);
    add_vec(1, 0, 0, 0, 1, 1, 1, 30);
    add_vec(1, 0, 0, 0, 1, 1, 0, 30);
    // C: FRAME_LEN=1 stream 0,15,7 back to back, then a stalled word
    add_vec(2, 0, 1, 0, 1, 1, 0, 0);
    add_vec(2, 0, 1, 15, 1, 1, 1, 0);
    add_vec(2, 0, 1, 7, 1, 1, 1, 15);
    add_vec(2, 0, 0, 0, 1, 1, 1, 7);
    add_vec(2, 0, 0, 0, 1, 1, 0, 7);
    add_vec(2, 0, 1, 9, 1, 1, 0, 7);
    add_vec(2, 0, 1, 3, 0, 0, 1, 9);
    add_vec(2, 0, 1, 3, 1, 1, 1, 9);
    add_vec(2, 0, 0, 0, 1, 1, 1, 3);
    add_vec(2, 0, 0, 0, 1, 1, 0, 3);

    // ---- reset -------------------------------------------------------------
    rst_n = 1'b0;
    clr_a = 0; clr_b = 0; clr_c = 0;
    ifa.in_valid = 0; ifa.cnt_in = 0; ifa.out_ready = 0;
    ifb.in_valid = 0; ifb.cnt_in = 0; ifb.out_ready = 0;
    ifc.in_valid = 0; ifc.cnt_in = 0; ifc.out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", int'(ifa.out_valid), 0);
    chk("reset sum_out", int'(ifa.sum_out), 0);
    chk("reset ovf", int'(ifa.ovf), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post-reset in_ready a", int'(ifa.in_ready), 1);
    chk("post-reset in_ready b", int'(ifb.in_ready), 1);
    chk("post-reset in_ready c", int'(ifc.in_ready), 1);

    // ---- table -------------------------------------------------------------
    foreach (vecs[i]) begin
      step(vecs[i].id, vecs[i].c, vecs[i].v, vecs[i].cnt, vecs[i].ordy,
           vecs[i].ir, vecs[i].ov, vecs[i].sum);
    end

    // ---- asynchronous reset mid-frame --------------------------------------
    for (int i = 0; i < 4; i++) step(0, 0, 1, 5, 1, 1, 0, -1);
    step(0, 0, 0, 0, 1, 1, 1, 20);
    step(0, 0, 1, 2, 1, 1, 0, 20);
    step(0, 0, 1, 2, 1, 1, 0, 20);
    @(posedge clk);
    #2;
    ifa.in_valid = 0;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", int'(ifa.out_valid), 0);
    chk("async reset sum_out", int'(ifa.sum_out), 0);
    chk("async reset in_ready", int'(ifa.in_ready), 1);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step(0, 0, 1, 1, 1, 1, 0, 0);
    step(0, 0, 1, 2, 1, 1, 0, 0);
    step(0, 0, 1, 3, 1, 1, 0, 0);
    step(0, 0, 1, 4, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 1, 10);
    step(0, 0, 0, 0, 1, 1, 0, 10);

    chk("scoreboard drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
